// File: rtl/tt_sweep_checker_if.sv
// Connects the truth-table sweeper to its harness: start and DUT response in,
// driven vector and sweep result out.
interface tt_sweep_checker_if #(
  parameter int N_IN = 4
);
  logic              start;
  logic              dut_f;
  logic [N_IN-1:0]   vec_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_count;
  logic [N_IN-1:0]   first_err_vec;

  modport master (
    output start, dut_f,
    input  vec_out, busy, done, pass, err_count, first_err_vec
  );

  modport slave (
    input  start, dut_f,
    output vec_out, busy, done, pass, err_count, first_err_vec
  );
endinterface

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper/checker for an N_IN-input combinational block.
// Optional build macro TT_SWEEP_STOP_ON_ERR_EN: end the sweep on the first mismatch.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | driving vectors, comparing at the end of each hold window
// DONE  | sweep finished, results held until start or reset
module tt_sweep_checker #(
  parameter int N_IN = 4,
  parameter int HOLD = 2,
  parameter logic [(2**N_IN)-1:0] EXPECT = 16'h6996
) (
  input  logic                clk,
  input  logic                rst,
  tt_sweep_checker_if.slave   bus
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = {N_IN{1'b1}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   first_q, first_d;
  logic              cmp_edge;
  logic              mismatch;

  // With HOLD=1 every RUN edge compares and the hold counter never moves.
  assign cmp_edge = (HOLD == 1) ? 1'b1 : (hold_q == HOLD_LAST);
  assign mismatch = (bus.dut_f != EXPECT[vec_q]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    first_d = first_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          vec_d   = '0;
          hold_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          first_d = '0;
        end
      end

      RUN: begin
        if (!cmp_edge) begin
          hold_d = hold_q + HW'(1);
        end else begin
          if (mismatch) begin
            err_d = err_q + (N_IN + 1)'(1);
            if (err_q == '0) first_d = vec_q;
          end
`ifdef TT_SWEEP_STOP_ON_ERR_EN
          if (mismatch || vec_q == VEC_LAST) begin
`else
          if (vec_q == VEC_LAST) begin
`endif
            // vec_out stays put: all-ones at the end, or the failing vector on early stop
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d  = vec_q + N_IN'(1);
            hold_d = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.vec_out       = vec_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_vec = first_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench: each sweep pushes its expected result computed from the
// fault pattern; per-DUT monitors pop and compare when done rises.
module tb_tt_sweep_checker;

  localparam int A_N = 4, A_HOLD = 2;
  localparam int B_N = 2, B_HOLD = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tt_sweep_checker_if #(.N_IN(A_N)) bus_a ();
  tt_sweep_checker_if #(.N_IN(B_N)) bus_b ();

  tt_sweep_checker #(.N_IN(A_N), .HOLD(A_HOLD), .EXPECT(16'h6996)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );
  tt_sweep_checker #(.N_IN(B_N), .HOLD(B_HOLD), .EXPECT(4'b1000)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  // Lab DUTs: A is 4-input XOR, B is 2-input AND, each with a per-vector fault mask
  logic [15:0] fault_a = '0;
  logic [3:0]  fault_b = '0;
  assign bus_a.dut_f = (^bus_a.vec_out) ^ fault_a[bus_a.vec_out];
  assign bus_b.dut_f = (&bus_b.vec_out) ^ fault_b[bus_b.vec_out];

  typedef struct {
    int   cycles;
    logic pass;
    int   errs;
    int   first;
    int   vec;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Result of a full sweep derived directly from which vectors are faulty.
  function automatic exp_t model(input int n, input int hold, input logic [15:0] mask);
    exp_t e;
    int nv = 1 << n;
    int errs = 0;
    int first = -1;
    for (int k = 0; k < nv; k++) begin
      if (mask[k]) begin
        errs++;
        if (first < 0) first = k;
      end
    end
    e.pass  = (errs == 0);
    e.first = (first < 0) ? 0 : first;
`ifdef TT_SWEEP_STOP_ON_ERR_EN
    if (errs > 0) begin
      e.errs   = 1;
      e.cycles = (first + 1) * hold;
      e.vec    = first;
    end else begin
      e.errs   = 0;
      e.cycles = nv * hold;
      e.vec    = nv - 1;
    end
`else
    e.errs   = errs;
    e.cycles = nv * hold;
    e.vec    = nv - 1;
`endif
    return e;
  endfunction

  // Monitor A
  initial begin
    int cyc = 0;
    logic busy_p = 1'b0, done_p = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0; busy_p = 1'b0; done_p = 1'b0;
      end else begin
        if (bus_a.busy) begin
          cyc = busy_p ? cyc + 1 : 1;
          chk("a_vec_during_run", int'(bus_a.vec_out), (cyc - 1) / A_HOLD);
        end
        if (bus_a.done && !done_p) begin
          if (q_a.size() == 0) chk("a_unexpected_done", 1, 0);
          else begin
            e = q_a.pop_front();
            chk("a_cycles_to_done", cyc, e.cycles);
            chk("a_pass", int'(bus_a.pass), int'(e.pass));
            chk("a_err_count", int'(bus_a.err_count), e.errs);
            chk("a_first_err_vec", int'(bus_a.first_err_vec), e.first);
            chk("a_final_vec", int'(bus_a.vec_out), e.vec);
            chk("a_busy_at_done", int'(bus_a.busy), 0);
          end
        end
        busy_p = bus_a.busy;
        done_p = bus_a.done;
      end
    end
  end

  // Monitor B
  initial begin
    int cyc = 0;
    logic busy_p = 1'b0, done_p = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0; busy_p = 1'b0; done_p = 1'b0;
      end else begin
        if (bus_b.busy) begin
          cyc = busy_p ? cyc + 1 : 1;
          chk("b_vec_during_run", int'(bus_b.vec_out), (cyc - 1) / B_HOLD);
        end
        if (bus_b.done && !done_p) begin
          if (q_b.size() == 0) chk("b_unexpected_done", 1, 0);
          else begin
            e = q_b.pop_front();
            chk("b_cycles_to_done", cyc, e.cycles);
            chk("b_pass", int'(bus_b.pass), int'(e.pass));
            chk("b_err_count", int'(bus_b.err_count), e.errs);
            chk("b_first_err_vec", int'(bus_b.first_err_vec), e.first);
            chk("b_final_vec", int'(bus_b.vec_out), e.vec);
          end
        end
        busy_p = bus_b.busy;
        done_p = bus_b.done;
      end
    end
  end

  task automatic run_a(input logic [15:0] mask, input bit mid_start);
    int i;
    fault_a = mask;
    q_a.push_back(model(A_N, A_HOLD, mask));
    bus_a.start = 1'b1;
    @(negedge clk); #1;
    bus_a.start = 1'b0;
    for (i = 0; i < 200 && q_a.size() != 0; i++) begin
      @(negedge clk); #1;
      bus_a.start = (mid_start && i == 10);
    end
    bus_a.start = 1'b0;
    if (q_a.size() != 0) begin
      chk("a_done_timeout", 0, 1);
      q_a.delete();
    end
  endtask

  task automatic run_b(input logic [3:0] mask);
    int i;
    fault_b = mask;
    q_b.push_back(model(B_N, B_HOLD, {12'h000, mask}));
    bus_b.start = 1'b1;
    @(negedge clk); #1;
    bus_b.start = 1'b0;
    for (i = 0; i < 100 && q_b.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (q_b.size() != 0) begin
      chk("b_done_timeout", 0, 1);
      q_b.delete();
    end
  endtask

  task automatic check_a_cleared(input string tag);
    chk({tag, "_vec_out"},  int'(bus_a.vec_out), 0);
    chk({tag, "_busy"},     int'(bus_a.busy), 0);
    chk({tag, "_done"},     int'(bus_a.done), 0);
    chk({tag, "_pass"},     int'(bus_a.pass), 0);
    chk({tag, "_err"},      int'(bus_a.err_count), 0);
    chk({tag, "_first"},    int'(bus_a.first_err_vec), 0);
  endtask

  initial begin
    int i;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    repeat (3) @(negedge clk);
    check_a_cleared("reset");
    chk("reset_b_busy", int'(bus_b.busy), 0);
    #1 rst = 1'b0;

    run_a(16'h0000, 1'b0);   // clean XOR
    run_a(16'hFFFF, 1'b0);   // inverted XOR
    run_a(16'h0400, 1'b0);   // single fault at vector 10
    run_a(16'h0000, 1'b1);   // start pulsed mid-run must be ignored
    run_a(16'h8000, 1'b0);   // fault only on the last vector

    // Asynchronous reset while vector 7 is driven
    fault_a = '0;
    bus_a.start = 1'b1;
    @(negedge clk); #1;
    bus_a.start = 1'b0;
    for (i = 0; i < 100 && bus_a.vec_out != 4'd7; i++) begin
      @(negedge clk); #1;
    end
    chk("reach_vec7", int'(bus_a.vec_out), 7);
    rst = 1'b1;
    #1;
    check_a_cleared("async_rst");
    @(negedge clk); #1;
    rst = 1'b0;

    run_a(16'h0000, 1'b0);   // re-sweep after reset
    for (int r = 0; r < 4; r++) begin
      logic [15:0] m;
      m = 16'($urandom) & 16'($urandom) & 16'($urandom);
      run_a(m, 1'b0);
    end

    run_b(4'b0000);
    run_b(4'b0100);
    for (int r = 0; r < 3; r++) run_b(4'($urandom));

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
